// File: rtl/machine_jk.sv
// ---------------------------------------------------------------------------
// machine_jk -- modulo-8 up/down counter built from three JK flip-flops.
//
// Ports
//   CLK    in   1  system clock, all state changes on the rising edge
//   RESET  in   1  synchronous active-low reset, forces S to 3'b000
//   x      in   1  direction: 0 = count up, 1 = count down
//   F      out  1  terminal-count flag (Mealy): up at 7 or down at 0
//   S      out  3  current count, S[2] = MSB
//
// jk_ff -- single JK flip-flop with synchronous active-low clear.
//
// Ports
//   clk_i    in   1  clock
//   rst_ni   in   1  synchronous active-low reset, forces q_o to 0
//   j_i      in   1  J input
//   k_i      in   1  K input
//   q_o      out  1  flip-flop state
// ---------------------------------------------------------------------------

module jk_ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  // NOTE: every path assigns q_d after the default, so no latch is inferred.
  always_comb begin
    q_d = q_q;
    unique case ({j_i, k_i})
      2'b00:   q_d = q_q;
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      2'b11:   q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops
  // sample their inputs from the same pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) q_q <= 1'b0;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

module machine_jk (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       x,
  output logic       F,
  output logic [2:0] S
);

  logic j_a;
  logic j_b;
  logic j_c;

  // A bit flips when every lower bit is at its terminal value for the
  // current direction (all ones going up, all zeros going down); XOR with x
  // folds both directions into the same carry/borrow chain.
  assign j_c = 1'b1;
  assign j_b = S[0] ^ x;
  assign j_a = (S[1] ^ x) & (S[0] ^ x);

  jk_ff u_ff_a (
    .clk_i  (CLK),
    .rst_ni (RESET),
    .j_i    (j_a),
    .k_i    (j_a),
    .q_o    (S[2])
  );

  jk_ff u_ff_b (
    .clk_i  (CLK),
    .rst_ni (RESET),
    .j_i    (j_b),
    .k_i    (j_b),
    .q_o    (S[1])
  );

  jk_ff u_ff_c (
    .clk_i  (CLK),
    .rst_ni (RESET),
    .j_i    (j_c),
    .k_i    (j_c),
    .q_o    (S[0])
  );

  // Terminal count depends on the live x, so it reacts between edges.
  assign F = (~x & (S == 3'd7)) | (x & (S == 3'd0));

endmodule

// File: tb/tb_machine_jk.sv
// ---------------------------------------------------------------------------
// tb_machine_jk -- directed self-checking bench for machine_jk and jk_ff.
// ---------------------------------------------------------------------------

module tb_machine_jk;

  logic       clk;
  logic       reset;
  logic       x;
  logic       f;
  logic [2:0] s;

  logic       ff_rst_n;
  logic       ff_j;
  logic       ff_k;
  logic       ff_q;

  int total = 0;
  int bad   = 0;

  machine_jk dut (
    .CLK   (clk),
    .RESET (reset),
    .x     (x),
    .F     (f),
    .S     (s)
  );

  jk_ff u_ff (
    .clk_i  (clk),
    .rst_ni (ff_rst_n),
    .j_i    (ff_j),
    .k_i    (ff_k),
    .q_o    (ff_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] exp_s;
    logic [2:0] up_seq [9];
    logic [2:0] dn_seq [3];
    logic [2:0] dc_seq [4];

    up_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    dn_seq = '{3'd7, 3'd6, 3'd5};
    dc_seq = '{3'd2, 3'd1, 3'd0, 3'd7};

    reset    = 1'b0;
    x        = 1'b0;
    ff_rst_n = 1'b0;
    ff_j     = 1'b0;
    ff_k     = 1'b0;

    // Reset held for two edges.
    step();
    step();
    check("rst_s", 8'(s), 8'd0);
    check("rst_f_x0", 8'(f), 8'd0);
    x = 1'b1;
    #1;
    check("rst_f_x1", 8'(f), 8'd1);
    check("rst_s_noedge", 8'(s), 8'd0);
    step();
    check("rst_hold_s", 8'(s), 8'd0);

    // Count up through the wrap.
    x     = 1'b0;
    reset = 1'b1;
    #1;
    check("up_f0", 8'(f), 8'd0);
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("up_s%0d", i), 8'(s), 8'(up_seq[i]));
      check($sformatf("up_f%0d", i), 8'(f), (up_seq[i] == 3'd7) ? 8'd1 : 8'd0);
    end

    // Count down from zero.
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("dn_start", 8'(s), 8'd0);
    x = 1'b1;
    #1;
    check("dn_f_pre", 8'(f), 8'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("dn_s%0d", i), 8'(s), 8'(dn_seq[i]));
      check($sformatf("dn_f%0d", i), 8'(f), 8'd0);
    end

    // Direction change at S=3.
    reset = 1'b0;
    step();
    reset = 1'b1;
    x     = 1'b0;
    step();
    step();
    step();
    check("dc_s3", 8'(s), 8'd3);
    x = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("dc_s%0d", i), 8'(s), 8'(dc_seq[i]));
      check($sformatf("dc_f%0d", i), 8'(f), (dc_seq[i] == 3'd0) ? 8'd1 : 8'd0);
    end

    // Mid-count reset at S=5 going down.
    step();
    step();
    check("mid_s5", 8'(s), 8'd5);
    reset = 1'b0;
    step();
    check("mid_rst_s", 8'(s), 8'd0);
    check("mid_rst_f", 8'(f), 8'd1);
    reset = 1'b1;
    step();
    exp_s = 3'd7;
    check("mid_rel_s", 8'(s), 8'(exp_s));

    // Stand-alone JK flip-flop: reset, hold, set, toggle, clear, reset priority.
    step();
    check("ff_rst", 8'(ff_q), 8'd0);
    ff_rst_n = 1'b1;
    ff_j = 1'b0; ff_k = 1'b0; step();
    check("ff_hold0", 8'(ff_q), 8'd0);
    ff_j = 1'b1; ff_k = 1'b0; step();
    check("ff_set", 8'(ff_q), 8'd1);
    ff_j = 1'b0; ff_k = 1'b0; step();
    check("ff_hold1", 8'(ff_q), 8'd1);
    ff_j = 1'b1; ff_k = 1'b1; step();
    check("ff_tog0", 8'(ff_q), 8'd0);
    step();
    check("ff_tog1", 8'(ff_q), 8'd1);
    ff_j = 1'b0; ff_k = 1'b1; step();
    check("ff_clr", 8'(ff_q), 8'd0);
    step();
    check("ff_clr_again", 8'(ff_q), 8'd0);
    ff_j = 1'b1; ff_k = 1'b0; ff_rst_n = 1'b0; step();
    check("ff_rst_prio", 8'(ff_q), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/machine_jk.md
MACHINE_JK -- requirements
Module: machine_jk

Interface
REQ-001 The block SHALL have the ports listed in REQ-002 to REQ-006, in that order.
REQ-002 CLK  input  1  Single system clock; all state changes occur on the rising edge.
REQ-003 RESET  input  1  Reset: synchronous and active-low, sampled on the rising edge of CLK.
REQ-004 x  input  1  Direction control: 0 = count up, 1 = count down.
REQ-005 F  output  1  Terminal-count flag (Mealy, combinational from S and x).
REQ-006 S  output  3  Current state; S[2] is the MSB.
REQ-007 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-008 The state SHALL be held in three JK flip-flops: A = S[2], B = S[1], C = S[0].
REQ-009 Each JK flip-flop SHALL behave as follows on the rising edge of CLK: J=0,K=0 holds; J=0,K=1 clears; J=1,K=0 sets; J=1,K=1 toggles.
REQ-010 The JK flip-flop SHALL be a separate submodule, instantiated three times.
REQ-011 Flip-flop C SHALL use J=K=1, so it toggles every non-reset cycle.
REQ-012 Flip-flop B SHALL use J=K=(S[0] XOR x).
REQ-013 Flip-flop A SHALL use J=K=(S[1] XOR x) AND (S[0] XOR x).
REQ-014 The result SHALL be a modulo-8 binary counter: S(next)=S+1 mod 8 when x=0, and S-1 mod 8 when x=1.
REQ-015 Wrap-around: 7 SHALL go to 0 when x=0, and 0 SHALL go to 7 when x=1, with no stall.
REQ-016 F SHALL be 1 exactly when (x=0 AND S=7) OR (x=1 AND S=0), and 0 otherwise.
REQ-017 F SHALL be purely combinational, with zero-cycle latency from x and S.
REQ-018 A change of x between edges SHALL affect only F immediately; the next transition uses the value of x sampled at the edge.
REQ-019 S SHALL change only on a rising edge of CLK; it SHALL be glitch-free between edges.
REQ-020 The block SHALL contain no latches, no X propagation after reset, and no asynchronous paths other than F.

Reset
REQ-021 When RESET=0 at a rising CLK edge, all three flip-flops SHALL go to 0 (S=3'b000), overriding their J/K values.
REQ-022 Reset SHALL take priority over x at every edge.
REQ-023 Asserting reset mid-count SHALL force S=000 at the next edge, whatever the count or direction.
REQ-024 While RESET=0, S SHALL stay at 000 on every edge.
REQ-025 While RESET=0, F SHALL still follow REQ-016: F=1 iff x=1, since S=0.
REQ-026 The first edge with RESET=1 SHALL perform a normal transition from 000.
REQ-027 Before the first reset edge the state is undefined; the bench SHALL apply reset first.

Verification
REQ-028 Reset: hold RESET=0 for 2 edges with x=0 -> S=000 and F=0; switch x to 1 -> F=1 with no clock edge.
REQ-029 Count up: release reset with x=0 and clock 9 edges -> S steps 1,2,3,4,5,6,7,0,1; F=1 only while S=7.
REQ-030 Count down: start from S=000, set x=1 and clock 3 edges -> S steps 7,6,5; F=1 before the first edge (S=0) and 0 afterwards.
REQ-031 Direction change: count up to S=3, set x=1 -> the next edges give S=2,1,0,7; F=1 only while S=0.
REQ-032 Reset mid-operation: at S=5 with x=1, drive RESET=0 for 1 edge -> S=000 at that edge; release with x=1 -> the next edge gives S=7.
REQ-033 Flip-flop check: force the submodule through hold, clear, set and toggle -> each outputs 0/1 exactly per REQ-009.
